uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning I_baud_tick pulses per bit period; even, legal range 8..32.
REQ-003 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values 1 or 2.
REQ-004 SHALL have port I_sys_clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port I_rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port I_rx_serial_data  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port I_baud_tick  input  1  one-cycle oversample enable.
REQ-008 SHALL have port I_parity_odd  input  1  parity sense: 1 = odd, 0 = even; ignored when parity is compiled out.
REQ-009 SHALL have port o_read_data  output  DATA_WIDTH  last received word.
REQ-010 SHALL have port o_read_data_valid  output  1  one-cycle pulse per completed frame.
REQ-011 SHALL have port o_frame_err  output  1  stop-bit error flag, qualified by valid.
REQ-012 SHALL have port o_parity_err  output  1  parity error flag, qualified by valid.
REQ-013 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL pass I_rx_serial_data through a 2-flop synchroniser; all decisions use the synchronised value only.
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL advance the sample counter (width $clog2(OVERSAMPLE)) only on cycles with I_baud_tick=1.
REQ-017 In IDLE, when the line is low and start detection is armed, SHALL go to START with the counter cleared.
REQ-018 In START, at the tick where the counter reaches OVERSAMPLE/2-1, SHALL resample the line:
- low: go to DATA, counter cleared.
- high (glitch): return to IDLE with no output activity.
REQ-019 In DATA, SHALL sample at counter==OVERSAMPLE-1, shift the bit in LSB-first, and go on after DATA_WIDTH bits:
- to PARITY when parity is compiled in;
- otherwise to STOP.
REQ-020 In PARITY, SHALL sample one bit at counter==OVERSAMPLE-1 and compare it with XOR(data)^I_parity_odd; a mismatch sets the pending parity error.
REQ-021 In STOP, SHALL sample STOP_BITS bits at counter==OVERSAMPLE-1 each; any low sample sets the pending frame error.
REQ-022 On the last stop-bit sample, SHALL in the same cycle:
- update o_read_data;
- pulse o_read_data_valid for exactly one cycle;
- drive o_frame_err and o_parity_err with the pending flags for that cycle only;
- enter IDLE.
REQ-023 SHALL deliver data even when an error flag is set.
REQ-024 o_read_data SHALL hold its value between valid pulses.
REQ-025 After a frame error, start detection SHALL be disarmed until the synchronised line is seen high in IDLE, so that a held-low break line yields exactly one frame.
REQ-026 Ticks arriving while in a state's final-sample cycle SHALL NOT be double-counted; the counter wraps to 0 at each sample point.

Reset
REQ-027 On I_rst=1 the block SHALL:
- enter IDLE;
- set start detection armed;
- clear counters, shift register and pending flags;
- set both synchroniser flops to 1;
- force o_read_data=0 and o_read_data_valid=o_frame_err=o_parity_err=o_busy=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no valid pulse.

Configuration
REQ-029 Macro UART_RX_CFG_PARITY_EN SHALL control the parity bit:
- defined: PARITY state and parity check are present.
- undefined: PARITY state is absent, o_parity_err is tied 0, I_parity_odd is unused, and frame length is 1+DATA_WIDTH+STOP_BITS bits.

Verification
REQ-030 Defaults, no parity, frame 0xA5 with a tick every clock -> one valid pulse, o_read_data=0xA5, both error flags 0.
REQ-031 Low glitch of 4 ticks on idle line -> no valid pulse, o_busy returns to 0 within OVERSAMPLE/2 ticks.
REQ-032 Byte 0x3C sent with stop bit 0 -> valid with o_frame_err=1; line then held low for 3 frames -> no further valid until the line returns high.
REQ-033 Parity compiled in, I_parity_odd=0, byte 0x07 sent with parity bit 0 -> o_parity_err=1; sent with parity bit 1 -> o_parity_err=0.
REQ-034 DATA_WIDTH=9, STOP_BITS=2, frames 0x1FF then 0x001 back-to-back -> two valid pulses with matching data; second stop bit driven low -> o_frame_err=1.
REQ-035 I_rst pulsed during bit 4 of a frame -> all outputs 0; next clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, stop/parity checking.
// Define UART_RX_CFG_PARITY_EN to add a parity bit between the data and stop bits.
module uart_rx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst,
  input  logic                  I_rx_serial_data,
  input  logic                  I_baud_tick,
  input  logic                  I_parity_odd,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_data_valid,
  output logic                  o_frame_err,
  output logic                  o_parity_err,
  output logic                  o_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] HALF_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_CFG_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                  sync1_q, sync2_q;
  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  armed_q, armed_d;
  logic                  ferr_pend_q, ferr_pend_d;
  logic                  perr_pend_q, perr_pend_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  parity_err_q, parity_err_d;
  logic                  rx_s;
  logic                  sample_pt;
  logic                  ferr_now;

  assign rx_s      = sync2_q;
  assign sample_pt = I_baud_tick && (cnt_q == LAST_CNT);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    armed_d      = armed_q;
    ferr_pend_d  = ferr_pend_q;
    perr_pend_d  = perr_pend_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    ferr_now     = ferr_pend_q | ~rx_s;

    if (I_baud_tick) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d       = '0;
        bit_cnt_d   = '0;
        ferr_pend_d = 1'b0;
        perr_pend_d = 1'b0;
        // A line held low after a bad stop bit must be seen high before re-arming.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (I_baud_tick && (cnt_q == HALF_CNT)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (sample_pt) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
`ifdef UART_RX_CFG_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_CFG_PARITY_EN
      ST_PARITY: begin
        if (sample_pt) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (rx_s != ((^shift_q) ^ I_parity_odd)) begin
            perr_pend_d = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (sample_pt) begin
          cnt_d = '0;
          if (bit_cnt_q == LAST_STOP) begin
            data_d       = shift_q;
            valid_d      = 1'b1;
            frame_err_d  = ferr_now;
            parity_err_d = perr_pend_q;
            armed_d      = ~ferr_now;
            ferr_pend_d  = 1'b0;
            perr_pend_d  = 1'b0;
            bit_cnt_d    = '0;
            state_d      = ST_IDLE;
          end else begin
            ferr_pend_d = ferr_now;
            bit_cnt_d   = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_sys_clk or posedge I_rst) begin
    if (I_rst) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      armed_q      <= 1'b1;
      ferr_pend_q  <= 1'b0;
      perr_pend_q  <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync1_q      <= I_rx_serial_data;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      armed_q      <= armed_d;
      ferr_pend_q  <= ferr_pend_d;
      perr_pend_q  <= perr_pend_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

`ifdef UART_RX_CFG_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  logic unused_parity;
  assign unused_parity = I_parity_odd ^ parity_err_q;
  assign o_parity_err  = 1'b0;
`endif

  assign o_read_data       = data_q;
  assign o_read_data_valid = valid_q;
  assign o_frame_err       = frame_err_q;
  assign o_busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: default 8N1 instance plus a 9-bit, 2-stop-bit instance.
module tb_uart_rx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       parity_odd = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  int         tick_div = 1;
  int         div_cnt = 0;

  logic [7:0] data_a;
  logic       valid_a, ferr_a, perr_a, busy_a;
  logic [8:0] data_b;
  logic       valid_b, ferr_b, perr_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt_a = 0, vcnt_b = 0, stray = 0;
  logic cap_ferr_a = 1'b0, cap_perr_a = 1'b0, cap_ferr_b = 1'b0;
  int n0;

  uart_rx_cfg dut_a (
    .I_sys_clk         (clk),
    .I_rst             (rst),
    .I_rx_serial_data  (rx_a),
    .I_baud_tick       (tick),
    .I_parity_odd      (parity_odd),
    .o_read_data       (data_a),
    .o_read_data_valid (valid_a),
    .o_frame_err       (ferr_a),
    .o_parity_err      (perr_a),
    .o_busy            (busy_a)
  );

  uart_rx_cfg #(.DATA_WIDTH(9), .OVERSAMPLE(OS), .STOP_BITS(2)) dut_b (
    .I_sys_clk         (clk),
    .I_rst             (rst),
    .I_rx_serial_data  (rx_b),
    .I_baud_tick       (tick),
    .I_parity_odd      (parity_odd),
    .o_read_data       (data_b),
    .o_read_data_valid (valid_b),
    .o_frame_err       (ferr_b),
    .o_parity_err      (perr_b),
    .o_busy            (busy_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      div_cnt = 0;
      tick = 1'b1;
    end else begin
      div_cnt = div_cnt + 1;
      tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a = vcnt_a + 1;
      cap_ferr_a = ferr_a;
      cap_perr_a = perr_a;
      $display("rx_a frame: data=0x%02h frame_err=%0b parity_err=%0b", data_a, ferr_a, perr_a);
    end else if (ferr_a || perr_a) begin
      stray = stray + 1;
    end
    if (valid_b) begin
      vcnt_b = vcnt_b + 1;
      cap_ferr_b = ferr_b;
      $display("rx_b frame: data=0x%03h frame_err=%0b", data_b, ferr_b);
    end else if (ferr_b || perr_b) begin
      stray = stray + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (got === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bit_a(input logic v);
    rx_a = v;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic bit_b(input logic v);
    rx_b = v;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  task automatic send_a(input logic [7:0] d, input logic par, input logic stop_v);
    bit_a(1'b0);
    for (int i = 0; i < 8; i++) bit_a(d[i]);
`ifdef UART_RX_CFG_PARITY_EN
    bit_a(par);
`else
    if (par) begin end
`endif
    bit_a(stop_v);
  endtask

  task automatic send_b(input logic [8:0] d, input logic s1, input logic s2);
    bit_b(1'b0);
    for (int i = 0; i < 9; i++) bit_b(d[i]);
    bit_b(s1);
    bit_b(s2);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", {24'd0, data_a}, 32'h0);
    chk("rst_valid", {31'd0, valid_a}, 32'h0);
    chk("rst_busy", {31'd0, busy_a}, 32'h0);
    chk("rst_flags", {30'd0, ferr_a, perr_a}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean 0xA5 frame, tick every clock
    n0 = vcnt_a;
    send_a(8'hA5, 1'b0, 1'b1);
    bit_a(1'b1);
    bit_a(1'b1);
    chk("a5_count", vcnt_a, n0 + 1);
    chk("a5_data_hold", {24'd0, data_a}, 32'hA5);
    chk("a5_ferr", {31'd0, cap_ferr_a}, 32'h0);
    chk("a5_perr", {31'd0, cap_perr_a}, 32'h0);
    chk("a5_busy", {31'd0, busy_a}, 32'h0);

    // Four-tick low glitch on idle line
    n0 = vcnt_a;
    rx_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", {31'd0, busy_a}, 32'h1);
    rx_a = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_busy_lo", {31'd0, busy_a}, 32'h0);
    chk("glitch_count", vcnt_a, n0);

    // 0x3C with bad stop bit, then break held for three frame times
    n0 = vcnt_a;
    send_a(8'h3C, 1'b0, 1'b0);
    chk("ferr_count", vcnt_a, n0 + 1);
    chk("ferr_flag", {31'd0, cap_ferr_a}, 32'h1);
    chk("ferr_data", {24'd0, data_a}, 32'h3C);
    repeat (3 * 11 * OS) @(negedge clk);
    chk("break_count", vcnt_a, n0 + 1);
    chk("break_busy", {31'd0, busy_a}, 32'h0);
    bit_a(1'b1);
    send_a(8'h12, 1'b0, 1'b1);
    bit_a(1'b1);
    chk("rearm_count", vcnt_a, n0 + 2);
    chk("rearm_data", {24'd0, data_a}, 32'h12);
    chk("rearm_ferr", {31'd0, cap_ferr_a}, 32'h0);

    // Tick every second clock
    tick_div = 2;
    n0 = vcnt_a;
    send_a(8'h81, 1'b0, 1'b1);
    bit_a(1'b1);
    chk("div2_count", vcnt_a, n0 + 1);
    chk("div2_data", {24'd0, data_a}, 32'h81);
    tick_div = 1;
    bit_a(1'b1);

    // 9-bit, two stop bits, back-to-back frames
    send_b(9'h1FF, 1'b1, 1'b1);
    chk("b1_count", vcnt_b, 1);
    chk("b1_data", {23'd0, data_b}, 32'h1FF);
    chk("b1_ferr", {31'd0, cap_ferr_b}, 32'h0);
    send_b(9'h001, 1'b1, 1'b1);
    chk("b2_count", vcnt_b, 2);
    chk("b2_data", {23'd0, data_b}, 32'h001);
    chk("b2_ferr", {31'd0, cap_ferr_b}, 32'h0);
    send_b(9'h0AB, 1'b1, 1'b0);
    bit_b(1'b1);
    chk("b3_count", vcnt_b, 3);
    chk("b3_data", {23'd0, data_b}, 32'h0AB);
    chk("b3_ferr", {31'd0, cap_ferr_b}, 32'h1);

`ifdef UART_RX_CFG_PARITY_EN
    // Even parity on 0x07: correct parity bit is 1
    parity_odd = 1'b0;
    n0 = vcnt_a;
    send_a(8'h07, 1'b0, 1'b1);
    bit_a(1'b1);
    chk("par_bad_count", vcnt_a, n0 + 1);
    chk("par_bad_flag", {31'd0, cap_perr_a}, 32'h1);
    chk("par_bad_data", {24'd0, data_a}, 32'h07);
    send_a(8'h07, 1'b1, 1'b1);
    bit_a(1'b1);
    chk("par_ok_count", vcnt_a, n0 + 2);
    chk("par_ok_flag", {31'd0, cap_perr_a}, 32'h0);
`endif

    // Reset pulsed during bit 4 of a frame
    n0 = vcnt_a;
    bit_a(1'b0);
    for (int i = 0; i < 4; i++) bit_a(i[0] ? 1'b0 : 1'b1);
    rx_a = 1'b0;
    repeat (OS / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_data", {24'd0, data_a}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'h0);
    chk("mid_rst_flags", {29'd0, valid_a, ferr_a, perr_a}, 32'h0);
    rst = 1'b0;
    rx_a = 1'b1;
    bit_a(1'b1);
    bit_a(1'b1);
    chk("mid_rst_count", vcnt_a, n0);
    send_a(8'h55, 1'b0, 1'b1);
    bit_a(1'b1);
    chk("post_rst_count", vcnt_a, n0 + 1);
    chk("post_rst_data", {24'd0, data_a}, 32'h55);
    chk("post_rst_ferr", {31'd0, cap_ferr_a}, 32'h0);

    chk("stray_flags", stray, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
